// File: rtl/alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one combinational ALU between NREQ requesters (for example the
// execute stage and the branch/address-gen unit). Each requester offers an
// op over a valid/ready handshake. A round-robin grant picks one op and
// latches it. The latched op is driven to the ALU for exactly one cycle (EXEC).
// The ALU result is then captured into a response register, together with the
// requester index and the requester's opaque tag.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid / req_ready      per-requester handshake; req_ready is one-hot
//   req_in0, req_in1           per-requester operands, 32 bits each, packed by index
//   req_func3, req_sub         per-requester ALU function select
//   req_tag                    per-requester opaque tag, TAG_W bits each
//   alu_in0/in1/func3/sub/en   drive the shared ALU
//   alu_out                    ALU result, combinational in the same cycle
//   rsp_valid / rsp_ready      response handshake
//   rsp_data, rsp_id, rsp_tag  result, issuing requester index, op tag
// ----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int NREQ  = 2,
    parameter int TAG_W = 4,
    parameter int ID_W  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*32-1:0]      req_in0,
    input  logic [NREQ*32-1:0]      req_in1,
    input  logic [NREQ*3-1:0]       req_func3,
    input  logic [NREQ-1:0]         req_sub,
    input  logic [NREQ*TAG_W-1:0]   req_tag,
    output logic [31:0]             alu_in0,
    output logic [31:0]             alu_in1,
    output logic [2:0]              alu_func3,
    output logic                    alu_sub,
    output logic                    alu_en,
    input  logic [31:0]             alu_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic [TAG_W-1:0]        rsp_tag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Round-robin pointer. It holds the index that has top priority in the
    // next search. That index is one past the last winner. A reset value of 0
    // therefore gives requester 0 top priority after reset.
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  ptr_d;

    // Latched op, driven to the ALU.
    logic [31:0]      op_in0_q;
    logic [31:0]      op_in1_q;
    logic [2:0]       op_func3_q;
    logic             op_sub_q;
    logic [TAG_W-1:0] op_tag_q;
    logic [ID_W-1:0]  op_id_q;

    // Grant search results and the fields of the winning requester.
    logic             accept_window;
    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  scan_idx;
    logic [31:0]      sel_in0;
    logic [31:0]      sel_in1;
    logic [2:0]       sel_func3;
    logic             sel_sub;
    logic [TAG_W-1:0] sel_tag;

    // Accept window: IDLE, or RESP while the consumer takes the current
    // response. The second case allows back-to-back ops, one every two cycles.
    // The search starts at ptr_q and wraps modulo NREQ. NREQ need not be a
    // power of two, so the wrap uses an explicit modulo.
    always_comb begin
        accept_window = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
        grant_found   = 1'b0;
        grant_idx     = '0;
        scan_idx      = '0;
        if (accept_window) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_idx = ID_W'((int'(ptr_q) + k) % NREQ);
                if (!grant_found && req_valid[scan_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = scan_idx;
                end
            end
        end
    end

    // One-hot ready and a mux of the winner's fields.
    always_comb begin
        req_ready = '0;
        sel_in0   = '0;
        sel_in1   = '0;
        sel_func3 = '0;
        sel_sub   = 1'b0;
        sel_tag   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_found && (grant_idx == ID_W'(i))) begin
                req_ready[i] = 1'b1;
            end
            if (grant_idx == ID_W'(i)) begin
                sel_in0   = req_in0[i*32 +: 32];
                sel_in1   = req_in1[i*32 +: 32];
                sel_func3 = req_func3[i*3 +: 3];
                sel_sub   = req_sub[i];
                sel_tag   = req_tag[i*TAG_W +: TAG_W];
            end
        end
        ptr_d = ID_W'((int'(grant_idx) + 1) % NREQ);
    end

    // Next-state logic. EXEC always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = grant_found ? EXEC : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Op latch and pointer. Both update only on an accepted grant. A requester
    // that drops valid before it is granted leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            op_in0_q   <= '0;
            op_in1_q   <= '0;
            op_func3_q <= '0;
            op_sub_q   <= 1'b0;
            op_tag_q   <= '0;
            op_id_q    <= '0;
        end else if (grant_found) begin
            ptr_q      <= ptr_d;
            op_in0_q   <= sel_in0;
            op_in1_q   <= sel_in1;
            op_func3_q <= sel_func3;
            op_sub_q   <= sel_sub;
            op_tag_q   <= sel_tag;
            op_id_q    <= grant_idx;
        end
    end

    // Response register. It captures the ALU result at the end of EXEC. It
    // holds its contents until the consumer takes them in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_tag   <= '0;
        end else if (state_q == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_out;
            rsp_id    <= op_id_q;
            rsp_tag   <= op_tag_q;
        end else if ((state_q == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // The ALU sees the latched op in every state. Only EXEC enables it.
    assign alu_in0   = op_in0_q;
    assign alu_in1   = op_in1_q;
    assign alu_func3 = op_func3_q;
    assign alu_sub   = op_sub_q;
    assign alu_en    = (state_q == EXEC);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam int NREQ  = 2;
    localparam int TAG_W = 4;
    localparam int ID_W  = 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*32-1:0]    req_in0 = '0;
    logic [NREQ*32-1:0]    req_in1 = '0;
    logic [NREQ*3-1:0]     req_func3 = '0;
    logic [NREQ-1:0]       req_sub = '0;
    logic [NREQ*TAG_W-1:0] req_tag = '0;
    logic [31:0]           alu_in0, alu_in1, alu_out;
    logic [2:0]            alu_func3;
    logic                  alu_sub, alu_en;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [31:0]           rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic [TAG_W-1:0]      rsp_tag;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int id1_count = 0;

    typedef struct packed {
        logic [31:0]      data;
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    rsp_t sb_q[$];
    int   grant_ids[$];
    int   grant_cycles[$];

    typedef struct {
        int          req;
        logic [31:0] in0;
        logic [31:0] in1;
        logic [2:0]  f3;
        logic        sub;
        logic [3:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Reference RV32 ALU that stands in for the shared ALU.
    function automatic logic [31:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  aluModel = sub ? (a - b) : (a + b);
            3'b001:  aluModel = a << b[4:0];
            3'b010:  aluModel = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011:  aluModel = (a < b) ? 32'd1 : 32'd0;
            3'b100:  aluModel = a ^ b;
            3'b101:  aluModel = sub ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  aluModel = a | b;
            default: aluModel = a & b;
        endcase
    endfunction

    assign alu_out = aluModel(alu_in0, alu_in1, alu_func3, alu_sub);

    alu_share_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in0   (req_in0),
        .req_in1   (req_in1),
        .req_func3 (req_func3),
        .req_sub   (req_sub),
        .req_tag   (req_tag),
        .alu_in0   (alu_in0),
        .alu_in1   (alu_in1),
        .alu_func3 (alu_func3),
        .alu_sub   (alu_sub),
        .alu_en    (alu_en),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_tag   (rsp_tag)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // The scoreboard pushes an expected response when a handshake completes.
    // It pops and compares when a response is consumed. Pop runs first, so a
    // back-to-back handshake in the same cycle queues behind the delivered one.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                if (rsp_id == 1'b1) id1_count++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_unexpected: got response id=%0d data=0x%08h, expected none", rsp_id, rsp_data);
                end else begin
                    rsp_t e;
                    e = sb_q.pop_front();
                    checkOutput("sb_data", rsp_data, e.data);
                    checkOutput("sb_id", 32'(rsp_id), 32'(e.id));
                    checkOutput("sb_tag", 32'(rsp_tag), 32'(e.tag));
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    rsp_t p;
                    p.data = aluModel(req_in0[i*32 +: 32], req_in1[i*32 +: 32], req_func3[i*3 +: 3], req_sub[i]);
                    p.id   = ID_W'(i);
                    p.tag  = req_tag[i*TAG_W +: TAG_W];
                    sb_q.push_back(p);
                    grant_ids.push_back(i);
                    grant_cycles.push_back(cycle);
                end
            end
            checks++;
            if (($countones(req_ready) > 1) || ((req_ready & ~req_valid) != '0)) begin
                errors++;
                $display("[TB] FAIL ready_onehot: got req_ready=%b, expected one-hot subset of req_valid=%b", req_ready, req_valid);
            end
        end
    end

    always @(negedge rst_n) sb_q.delete();

    task automatic setReq(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f3, input logic s, input logic [3:0] t);
        req_in0[i*32 +: 32]       = a;
        req_in1[i*32 +: 32]       = b;
        req_func3[i*3 +: 3]       = f3;
        req_sub[i]                = s;
        req_tag[i*TAG_W +: TAG_W] = t;
    endtask

    task automatic waitReady(input int i, output bit ok);
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (req_ready[i]) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout_ready%0d: got no grant, expected grant within 20 cycles", i);
        end
    endtask

    task automatic waitRspValid(output bit ok);
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout_rsp: got rsp_valid=0, expected 1 within 20 cycles");
        end
    endtask

    task automatic doReset();
        req_valid = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single op, with the response taken immediately. The bench checks the
    // accept -> ALU_EN -> RSP_VALID timing and the response contents.
    task automatic applyStimulus(input vec_t v);
        bit ok;
        setReq(v.req, v.in0, v.in1, v.f3, v.sub, v.tag);
        req_valid = '0;
        req_valid[v.req] = 1'b1;
        waitReady(v.req, ok);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        checkOutput("exec_alu_en", 32'(alu_en), 32'd1);
        checkOutput("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("resp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("resp_alu_en", 32'(alu_en), 32'd0);
        checkOutput("vec_data", rsp_data, v.exp);
        checkOutput("vec_id", 32'(rsp_id), 32'(v.req));
        checkOutput("vec_tag", 32'(rsp_tag), 32'(v.tag));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        logic [31:0] snap_data;
        logic [ID_W-1:0] snap_id;
        logic [TAG_W-1:0] snap_tag;
        int id1_snap;

        vecs[0]  = '{0, 32'd5,          32'd7,          3'b000, 1'b0, 4'd3,  32'd12};
        vecs[1]  = '{1, 32'd3,          32'd5,          3'b000, 1'b1, 4'd9,  32'hFFFF_FFFE};
        vecs[2]  = '{0, 32'h0000_F0F0,  32'h0000_FF00,  3'b111, 1'b0, 4'd1,  32'h0000_F000};
        vecs[3]  = '{1, 32'h0000_F0F0,  32'h0000_FF00,  3'b110, 1'b0, 4'd2,  32'h0000_FFF0};
        vecs[4]  = '{0, 32'h0000_F0F0,  32'h0000_FF00,  3'b100, 1'b0, 4'd4,  32'h0000_0FF0};
        vecs[5]  = '{1, 32'd1,          32'd4,          3'b001, 1'b0, 4'd5,  32'h0000_0010};
        vecs[6]  = '{0, 32'h8000_0000,  32'd4,          3'b101, 1'b0, 4'd6,  32'h0800_0000};
        vecs[7]  = '{1, 32'h8000_0000,  32'd4,          3'b101, 1'b1, 4'd7,  32'hF800_0000};
        vecs[8]  = '{0, 32'hFFFF_FFFF,  32'd1,          3'b010, 1'b0, 4'd8,  32'd1};
        vecs[9]  = '{1, 32'hFFFF_FFFF,  32'd1,          3'b011, 1'b0, 4'd10, 32'd0};
        vecs[10] = '{0, 32'hFFFF_FFFF,  32'd2,          3'b000, 1'b0, 4'd15, 32'd1};
        vecs[11] = '{1, 32'd0,          32'd0,          3'b000, 1'b1, 4'd0,  32'd0};

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        checkOutput("rst_alu_en", 32'(alu_en), 32'd0);
        checkOutput("rst_alu_in0", alu_in0, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] table vectors");
        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Both requesters held with an always-ready consumer: grants alternate
        // 0,1,0,1 and are spaced two cycles apart.
        $display("[TB] round robin");
        doReset();
        grant_ids.delete();
        grant_cycles.delete();
        setReq(0, 32'd10, 32'd20, 3'b000, 1'b0, 4'd1);
        setReq(1, 32'd100, 32'd1, 3'b000, 1'b1, 4'd2);
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        repeat (10) @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(negedge clk);
        checks++;
        if (grant_ids.size() < 4) begin
            errors++;
            $display("[TB] FAIL rr_count: got %0d grants, expected at least 4", grant_ids.size());
        end else begin
            for (int g = 0; g < 4; g++) begin
                checkOutput($sformatf("rr_grant%0d", g), 32'(grant_ids[g]), 32'(g % 2));
                if (g > 0) checkOutput($sformatf("rr_gap%0d", g), 32'(grant_cycles[g] - grant_cycles[g-1]), 32'd2);
            end
        end

        // Consumer stall: the response holds stable and nothing is accepted.
        // A new grant appears in the same cycle that the consumer raises ready.
        $display("[TB] response stall");
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        waitRspValid(ok);
        snap_data = rsp_data;
        snap_id   = rsp_id;
        snap_tag  = rsp_tag;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
            checkOutput("stall_data", rsp_data, snap_data);
            checkOutput("stall_id", 32'(rsp_id), 32'(snap_id));
            checkOutput("stall_tag", 32'(rsp_tag), 32'(snap_tag));
            checkOutput("stall_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("unstall_grant", 32'(req_ready), 32'(2'b01 << (snap_id ^ 1'b1)));
        @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(negedge clk);

        // Reset during EXEC discards the op and returns the pointer to 0.
        $display("[TB] reset in exec");
        setReq(1, 32'd1, 32'd1, 3'b000, 1'b0, 4'd3);
        req_valid = 2'b10;
        waitReady(1, ok);
        @(posedge clk);
        #1 req_valid = '0;
        checkOutput("pre_rst_alu_en", 32'(alu_en), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_exec_alu_en", 32'(alu_en), 32'd0);
        checkOutput("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        grant_ids.delete();
        req_valid = 2'b11;
        waitReady(0, ok);
        @(posedge clk);
        #1 req_valid = '0;
        checks++;
        if (grant_ids.size() == 0 || grant_ids[0] != 0) begin
            errors++;
            $display("[TB] FAIL rst_first_grant: got %0d, expected 0", (grant_ids.size() == 0) ? -1 : grant_ids[0]);
        end
        repeat (4) @(negedge clk);

        // Requester 1 withdraws before it is granted. It produces no response.
        $display("[TB] withdrawn request");
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        waitRspValid(ok);
        @(posedge clk);
        #1 req_valid = 2'b10;
        id1_snap = id1_count;
        repeat (2) begin
            @(negedge clk);
            checkOutput("withdraw_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("withdraw_no_id1", 32'(id1_count), 32'(id1_snap));
        checkOutput("withdraw_idle", 32'(rsp_valid), 32'd0);
        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
